// File: rtl/div_seq.sv
// div_seq: sequential 32-bit DIV/DIVU unit beside EXE (radix-2 restoring).
// Ports: clk, reset(sync, active-low), start, signed_op, cancel, dividend,
//   divisor -> stall_req, busy, done, quotient(lo), remainder(hi).
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips the iteration loop.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] rem_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [4:0]  cnt;
  logic        q_neg;
  logic        r_neg;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        take;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        zero_div;

  assign a_abs = (signed_op && dividend[31]) ? -dividend : dividend;
  assign b_abs = (signed_op && divisor[31]) ? -divisor : divisor;

  // The partial remainder always stays below the divisor, so the
  // shifted value fits 33 bits and diff[32] is a reliable sign bit.
  assign shifted = {rem_q, dvd_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign take    = ~diff[32];
  assign rem_nx  = take ? diff[31:0] : shifted[31:0];
  assign quo_nx  = {dvd_q[30:0], take};
  assign q_fix   = q_neg ? -quo_nx : quo_nx;
  assign r_fix   = r_neg ? -rem_nx : rem_nx;

`ifdef DIV_ZERO_FAST_EN
  assign zero_div = (divisor == 32'd0);
`else
  assign zero_div = 1'b0;
`endif

  assign stall_req = ((state == IDLE) && start)
                   || (state == CALC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
    end else if (cancel) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          done <= 1'b0;
          if (start) begin
            dvd_q <= a_abs;
            dvs_q <= b_abs;
            rem_q <= '0;
            cnt   <= 5'd31;
            q_neg <= signed_op & (dividend[31] ^ divisor[31]);
            r_neg <= signed_op & dividend[31];
            busy  <= 1'b1;
            if (zero_div) begin
              // Same values the full loop would produce for /0.
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= (signed_op && dividend[31]) ? 32'd1 : '1;
              remainder <= dividend;
            end else begin
              state <= CALC;
            end
          end
        end
        (state == CALC): begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          if (cnt == 5'd0) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_fix;
            remainder <= r_fix;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        (state == DONE): begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random checks of div_seq against
// an arithmetic reference model of the divide sequencer.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  div_seq dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_op(signed_op),
    .cancel(cancel),
    .dividend(dividend),
    .divisor(divisor),
    .stall_req(stall_req),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h",
               n, $time, act, exp);
    end
  endtask

  // Truncating division; x/0 gives all-ones (sign fixed) and r = x.
  function automatic void ref_div(input bit sg,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
    longint la;
    longint lb;
    if (b == 32'd0) begin
      q = (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q = 32'(la / lb);
      r = 32'(la % lb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Model: m_cnt = CALC cycles left; m_done = result cycle.
  int          m_cnt;
  bit          m_done;
  logic [31:0] m_q;
  logic [31:0] m_r;
  logic [31:0] p_q;
  logic [31:0] p_r;

  always @(posedge clk) begin : model
    logic [31:0] tq;
    logic [31:0] tr;
    if (!reset) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (cancel) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_q    <= p_q;
        m_r    <= p_r;
      end
    end else if (start) begin
      ref_div(signed_op, dividend, divisor, tq, tr);
      p_q <= tq;
      p_r <= tr;
      if (FAST && divisor == 32'd0) begin
        m_done <= 1'b1;
        m_q    <= tq;
        m_r    <= tr;
      end else begin
        m_cnt <= 32;
      end
    end
  end

  always @(negedge clk) begin
    bit idle;
    if (chk_en) begin
      idle = (m_cnt == 0) && !m_done;
      chk("stall_req", 32'(stall_req),
          32'((idle && start) || m_cnt > 0));
      chk("busy", 32'(busy), 32'(m_cnt > 0 || m_done));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit sg, input logic [31:0] a,
                        input logic [31:0] b, input bit tog,
                        output int dc, output int ns);
    dc = -1;
    ns = 0;
    start = 1'b1;
    signed_op = sg;
    dividend = a;
    divisor = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall_req) ns++;
      if (done) begin
        dc = k;
        break;
      end
      step();
      if (tog) begin
        dividend = $urandom;
        divisor = $urandom;
        signed_op = 1'($urandom);
      end
    end
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick(input bit dvs);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = dvs ? 32'd0 : 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'd1;
      3: v = 32'($urandom_range(0, 20));
      4: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int dc;
    int ns;
    logic [31:0] q;
    logic [31:0] r;

    reset = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    cancel = 1'b0;
    dividend = '0;
    divisor = '0;

    // Pin the reference model to hand-computed values.
    ref_div(1'b0, 32'd100, 32'd7, q, r);
    chk("ref_100_7_q", q, 32'd14);
    chk("ref_100_7_r", r, 32'd2);
    ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r);
    chk("ref_m7_2_q", q, 32'hFFFF_FFFD);
    chk("ref_m7_2_r", r, 32'hFFFF_FFFF);
    ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r);
    chk("ref_min_m1_q", q, 32'h8000_0000);
    chk("ref_min_m1_r", r, 32'd0);
    ref_div(1'b1, 32'hFFFF_FFF0, 32'd0, q, r);
    chk("ref_neg_z_q", q, 32'd1);
    chk("ref_neg_z_r", r, 32'hFFFF_FFF0);

    step();
    step();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk_en = 1'b1;
    step();
    reset = 1'b1;
    step();

    run_op(1'b0, 32'd100, 32'd7, 1'b0, dc, ns);
    chk("divu_lat", 32'(dc), 32'd33);
    chk("divu_stall", 32'(ns), 32'd33);
    chk("divu_q", quotient, 32'd14);
    chk("divu_r", remainder, 32'd2);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, dc, ns);
    chk("div_neg_q", quotient, 32'hFFFF_FFFD);
    chk("div_neg_r", remainder, 32'hFFFF_FFFF);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, dc, ns);
    chk("div_min_q", quotient, 32'h8000_0000);
    chk("div_min_r", remainder, 32'd0);

    run_op(1'b0, 32'h1234_5678, 32'd0, 1'b0, dc, ns);
    chk("dz_lat", 32'(dc), FAST ? 32'd1 : 32'd33);
    chk("dz_stall", 32'(ns), FAST ? 32'd1 : 32'd33);
    chk("dz_q", quotient, 32'hFFFF_FFFF);
    chk("dz_r", remainder, 32'h1234_5678);

    run_op(1'b0, 32'd5000, 32'd13, 1'b1, dc, ns);
    chk("tog_lat", 32'(dc), 32'd33);
    chk("tog_q", quotient, 32'd384);
    chk("tog_r", remainder, 32'd8);

    start = 1'b1;
    signed_op = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd3;
    repeat (10) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_done", 32'(done), 32'd0);
    chk("cancel_q", quotient, 32'd384);
    chk("cancel_r", remainder, 32'd8);
    repeat (36) step();

    run_op(1'b0, 32'd9, 32'd3, 1'b0, dc, ns);
    chk("after_cancel_q", quotient, 32'd3);
    chk("after_cancel_r", remainder, 32'd0);

    start = 1'b1;
    dividend = 32'd77;
    divisor = 32'd5;
    repeat (5) step();
    reset = 1'b0;
    start = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    step();
    reset = 1'b1;

    for (int i = 0; i < 2500; i++) begin
      step();
      start = ($urandom_range(0, 3) != 0);
      signed_op = 1'($urandom);
      dividend = pick(1'b0);
      divisor = pick(1'b1);
      cancel = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 399) != 0);
    end
    step();
    reset = 1'b1;
    cancel = 1'b0;
    start = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
